// File: rtl/multi_osc_pkg.sv
// multi_osc_pkg: shared types and helpers for the multi-channel DDS engine.
//   DAC_CMD       - upper nibble of every DAC command word
//   osc_state_e   - per-channel frame sequencer states
//   phase_wrap()  - modular phase add: (phase + freq) folded back below modulus
package multi_osc_pkg;

  localparam logic [3:0] DAC_CMD = 4'b0011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WAIT,
    ST_CAPTURE,
    ST_SEND,
    ST_HOLD
  } osc_state_e;

  // Both operands are below modulus, so one conditional subtract suffices.
  // The extra sum bit keeps the carry when phase+freq overflows the word.
  function automatic logic [31:0] phase_wrap(input logic [31:0] phase,
                                             input logic [31:0] freq,
                                             input logic [31:0] modulus);
    logic [32:0] sum;
    sum = {1'b0, phase} + {1'b0, freq};
    if (sum >= {1'b0, modulus}) sum = sum - {1'b0, modulus};
    return sum[31:0];
  endfunction

endpackage

// File: rtl/sample_timer.sv
// sample_timer: free-running sample-period counter.
//   clock       in  system clock
//   reset       in  synchronous, active-high
//   sample_tick out one-cycle pulse while the counter sits on its last value
// Period is exactly SAMPLE_INTERVAL cycles; first tick SAMPLE_INTERVAL-1
// cycles after reset is released.
module sample_timer #(
  parameter int SAMPLE_INTERVAL = 1909
) (
  input  logic clock,
  input  logic reset,
  output logic sample_tick
);

  localparam int TW = (SAMPLE_INTERVAL > 1) ? $clog2(SAMPLE_INTERVAL) : 1;
  localparam logic [TW-1:0] LAST = TW'(SAMPLE_INTERVAL - 1);

  logic [TW-1:0] timer_q, timer_d;

  always_comb begin
    timer_d = (timer_q == LAST) ? '0 : timer_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) timer_q <= '0;
    else       timer_q <= timer_d;
  end

  assign sample_tick = (timer_q == LAST) && !reset;

endmodule

// File: rtl/multi_osc_engine.sv
// multi_osc_engine: multi-channel DDS oscillator core.
// Each sample tick walks every channel once: present the LUT address from the
// pre-increment phase, wait out the registered LUT, capture the sample into a
// 24-bit DAC command {0011, channel mask, sample}, strobe dac_send when the
// driver is free, then hold until the driver finishes.
// Ports:
//   clock, reset      system clock, synchronous active-high reset
//   freq_in/freq_load per-channel frequency words (ch0 in LSBs) + load strobe
//   lut_addr/lut_data external registered sine LUT (1-cycle latency)
//   dac_data/dac_send/dac_busy  serial DAC driver handshake
//   sample_tick       one-cycle pulse at start of each sample period
//   overrun           sticky: tick seen while a frame was still running
//   sync_in           (only with MULTI_OSC_SYNC_EN) zero all phases on tick
// Optional build macro: MULTI_OSC_SYNC_EN adds sync_in and the phase reset path.
module multi_osc_engine
  import multi_osc_pkg::*;
#(
  parameter int CHANNELS        = 2,
  parameter int SAMPLE_INTERVAL = 1909,
  parameter int PHASE_MOD       = 44000,
  parameter int PHASE_WIDTH     = 16,
  parameter int LUT_ADDR_WIDTH  = 11,
  parameter int LUT_SHIFT       = 5,
  parameter int SAMPLE_WIDTH    = 16
) (
`ifdef MULTI_OSC_SYNC_EN
  input  logic                            sync_in,
`endif
  input  logic                            clock,
  input  logic                            reset,
  input  logic [CHANNELS*PHASE_WIDTH-1:0] freq_in,
  input  logic                            freq_load,
  output logic [LUT_ADDR_WIDTH-1:0]       lut_addr,
  input  logic [SAMPLE_WIDTH-1:0]         lut_data,
  output logic [23:0]                     dac_data,
  output logic                            dac_send,
  input  logic                            dac_busy,
  output logic                            sample_tick,
  output logic                            overrun
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [PHASE_WIDTH-1:0] FREQ_MAX = PHASE_WIDTH'(PHASE_MOD - 1);
  localparam logic [CW-1:0]          LAST_CH  = CW'(CHANNELS - 1);

  typedef logic [CHANNELS-1:0][PHASE_WIDTH-1:0] word_arr_t;

  osc_state_e                state_q, state_d;
  logic [CW-1:0]             ch_q, ch_d;
  logic                      hold_cnt_q, hold_cnt_d;
  word_arr_t                 phase_q, phase_d;
  word_arr_t                 shadow_q, shadow_d;
  word_arr_t                 freq_q, freq_d;
  word_arr_t                 freq_clamped;
  logic [LUT_ADDR_WIDTH-1:0] lut_addr_q, lut_addr_d;
  logic [23:0]               dac_data_q, dac_data_d;
  logic                      dac_send_q, dac_send_d;
  logic                      overrun_q, overrun_d;
  logic                      tick_accept;
  logic                      sync_zero;

  sample_timer #(
    .SAMPLE_INTERVAL(SAMPLE_INTERVAL)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .sample_tick(sample_tick)
  );

  // A tick only starts a frame from IDLE; otherwise it is dropped entirely.
  assign tick_accept = sample_tick && (state_q == ST_IDLE);

`ifdef MULTI_OSC_SYNC_EN
  assign sync_zero = tick_accept && sync_in;
`else
  assign sync_zero = 1'b0;
`endif

  always_comb begin
    freq_clamped = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      freq_clamped[c] = (freq_in[c*PHASE_WIDTH +: PHASE_WIDTH] > FREQ_MAX) ?
                        FREQ_MAX : freq_in[c*PHASE_WIDTH +: PHASE_WIDTH];
    end
  end

  // State register and all datapath flops
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ch_q       <= '0;
      hold_cnt_q <= 1'b0;
      phase_q    <= '0;
      shadow_q   <= '0;
      freq_q     <= '0;
      lut_addr_q <= '0;
      dac_data_q <= '0;
      dac_send_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      hold_cnt_q <= hold_cnt_d;
      phase_q    <= phase_d;
      shadow_q   <= shadow_d;
      freq_q     <= freq_d;
      lut_addr_q <= lut_addr_d;
      dac_data_q <= dac_data_d;
      dac_send_q <= dac_send_d;
      overrun_q  <= overrun_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (sample_tick) begin
          state_d = ST_ADDR;
          ch_d    = '0;
        end
      end
      ST_ADDR:    state_d = ST_WAIT;
      ST_WAIT:    state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_SEND;
      ST_SEND: begin
        if (!dac_busy) begin
          state_d    = ST_HOLD;
          hold_cnt_d = 1'b0;
        end
      end
      ST_HOLD: begin
        // First HOLD cycle is unconditional so the driver has time to raise busy.
        if (!hold_cnt_q) begin
          hold_cnt_d = 1'b1;
        end else if (!dac_busy) begin
          if (ch_q == LAST_CH) begin
            state_d = ST_IDLE;
          end else begin
            ch_d    = ch_q + 1'b1;
            state_d = ST_ADDR;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    shadow_d   = freq_load ? freq_clamped : shadow_q;
    freq_d     = freq_q;
    phase_d    = phase_q;
    lut_addr_d = lut_addr_q;
    dac_data_d = dac_data_q;
    dac_send_d = 1'b0;
    overrun_d  = overrun_q | (sample_tick && (state_q != ST_IDLE));

    if (tick_accept) begin
      // shadow_d already carries a same-cycle load, so it applies to this tick.
      freq_d = shadow_d;
      if (sync_zero) phase_d = '0;
    end

    case (state_q)
      ST_ADDR: begin
        lut_addr_d     = LUT_ADDR_WIDTH'(phase_q[ch_q] >> LUT_SHIFT);
        phase_d[ch_q]  = PHASE_WIDTH'(phase_wrap(32'(phase_q[ch_q]),
                                                 32'(freq_q[ch_q]),
                                                 32'(PHASE_MOD)));
      end
      ST_CAPTURE: dac_data_d = {DAC_CMD, 4'b0001 << ch_q, 16'(lut_data)};
      ST_SEND:    dac_send_d = !dac_busy;
      default: ;
    endcase
  end

  assign lut_addr = lut_addr_q;
  assign dac_data = dac_data_q;
  assign dac_send = dac_send_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_multi_osc_engine.sv
// Scoreboard bench for multi_osc_engine (CHANNELS=2, SAMPLE_INTERVAL=40).
// Stimulus pushes the expected DAC word and LUT address for every channel of
// each accepted tick; a monitor pops and compares on every dac_send pulse.
// Build with MULTI_OSC_SYNC_EN defined to exercise sync_in on the 5th tick.
module tb_multi_osc_engine;
  localparam int CH   = 2;
  localparam int SI   = 40;
  localparam int PW   = 16;
  localparam int AW   = 11;
  localparam int SW   = 16;
  localparam int PMOD = 44000;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [CH*PW-1:0] freq_in = '0;
  logic            freq_load = 1'b0;
  logic            dac_busy = 1'b0;
  logic [AW-1:0]   lut_addr;
  logic [SW-1:0]   lut_data = '0;
  logic [23:0]     dac_data;
  logic            dac_send;
  logic            sample_tick;
  logic            overrun;
`ifdef MULTI_OSC_SYNC_EN
  logic            sync_in = 1'b0;
`endif

  always #5 clock = ~clock;

  multi_osc_engine #(
    .CHANNELS       (CH),
    .SAMPLE_INTERVAL(SI),
    .PHASE_MOD      (PMOD),
    .PHASE_WIDTH    (PW),
    .LUT_ADDR_WIDTH (AW),
    .LUT_SHIFT      (5),
    .SAMPLE_WIDTH   (SW)
  ) dut (
`ifdef MULTI_OSC_SYNC_EN
    .sync_in    (sync_in),
`endif
    .clock      (clock),
    .reset      (reset),
    .freq_in    (freq_in),
    .freq_load  (freq_load),
    .lut_addr   (lut_addr),
    .lut_data   (lut_data),
    .dac_data   (dac_data),
    .dac_send   (dac_send),
    .dac_busy   (dac_busy),
    .sample_tick(sample_tick),
    .overrun    (overrun)
  );

  typedef struct packed {
    logic [23:0]   data;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   ph[CH];
  int   sh[CH];
  int   act[CH];
  logic send_prev = 1'b0;

  // Arbitrary but address-unique sine LUT stand-in
  function automatic logic [15:0] lut_fn(input logic [10:0] a);
    return {a, 5'b10110} ^ 16'h9C3A;
  endfunction

  always @(posedge clock) lut_data <= lut_fn(lut_addr);
  always @(posedge clock) cyc <= reset ? 0 : cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Monitor: scoreboard pops on dac_send, tick timing checked every tick
  always @(negedge clock) begin
    if (!reset) begin
      if (dac_send) begin
        check("send_width", {31'b0, send_prev}, 32'd0);
        check("sb_nonempty", {31'b0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          check("dac_data", {8'b0, dac_data}, {8'b0, sb[0].data});
          check("lut_addr", {21'b0, lut_addr}, {21'b0, sb[0].addr});
          void'(sb.pop_front());
        end
      end
      if (sample_tick || (cyc % SI == SI - 1))
        check("tick_timing", {31'b0, sample_tick}, {31'b0, (cyc % SI == SI - 1)});
    end
    send_prev <= dac_send;
  end

  // Advance to the negedge inside the next tick cycle
  task automatic to_tick();
    int n = 0;
    @(negedge clock);
    while ((cyc % SI) != SI - 1 && n < 2 * SI) begin
      @(negedge clock);
      n++;
    end
    check("tick_reached", {31'b0, sample_tick}, 32'd1);
  endtask

  // Drive a load strobe for one cycle starting at the current negedge
  task automatic load(input int f0, input int f1);
    freq_in   = {PW'(f1), PW'(f0)};
    freq_load = 1'b1;
    sh[0] = (f0 > PMOD - 1) ? PMOD - 1 : f0;
    sh[1] = (f1 > PMOD - 1) ? PMOD - 1 : f1;
    @(negedge clock);
    freq_load = 1'b0;
  endtask

  task automatic accept();
    for (int c = 0; c < CH; c++) act[c] = sh[c];
  endtask

  task automatic push_frame(input bit sync);
    exp_t e;
    logic [AW-1:0] a;
    for (int c = 0; c < CH; c++) begin
      if (sync) ph[c] = 0;
      a = AW'(ph[c] >> 5);
      e.addr = a;
      e.data = {4'b0011, 4'(1 << c), lut_fn(a)};
      sb.push_back(e);
      ph[c] = (ph[c] + act[c]) % PMOD;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int sends;
    for (int c = 0; c < CH; c++) begin ph[c] = 0; sh[c] = 0; act[c] = 0; end

    repeat (3) @(negedge clock);
    check("rst_lut_addr", {21'b0, lut_addr}, 32'd0);
    check("rst_dac_data", {8'b0, dac_data}, 32'd0);
    check("rst_dac_send", {31'b0, dac_send}, 32'd0);
    check("rst_tick", {31'b0, sample_tick}, 32'd0);
    check("rst_overrun", {31'b0, overrun}, 32'd0);
    reset = 1'b0;

    // T1: frequencies still zero
    to_tick(); accept(); push_frame(0);
    repeat (15) @(negedge clock);
    load(220, 1000);
    // T2..T4: addresses 0/0, then 6/31, then 13/62
    to_tick(); accept(); push_frame(0);
    to_tick(); accept(); push_frame(0);
    to_tick(); accept(); push_frame(0);

    // T5: phase sync (when built in)
    to_tick();
`ifdef MULTI_OSC_SYNC_EN
    sync_in = 1'b1;
    accept(); push_frame(1);
    @(negedge clock);
    sync_in = 1'b0;
`else
    accept(); push_frame(0);
`endif

    // T6: load on the tick cycle itself, ch1 clamps 50000 -> 43999
    to_tick(); load(43999, 50000); accept(); push_frame(0);
    to_tick(); accept(); push_frame(0);
    to_tick(); accept(); push_frame(0);

    // T9: mid-frame load must not affect the running frame
    to_tick(); accept(); push_frame(0);
    repeat (2) @(negedge clock);
    load(300, 100);
    to_tick(); accept(); push_frame(0);
    check("overrun_clear", {31'b0, overrun}, 32'd0);

    // T11: DAC busy for 100 cycles; the next two ticks are dropped
    to_tick(); accept(); push_frame(0);
    dac_busy = 1'b1;
    sends = 0;
    repeat (100) begin
      @(negedge clock);
      if (dac_send) sends++;
    end
    check("no_send_while_busy", sends, 32'd0);
    check("overrun_set", {31'b0, overrun}, 32'd1);
    dac_busy = 1'b0;

    // Next accepted tick: phase advanced only once since T11
    to_tick(); accept(); push_frame(0);
    repeat (30) @(negedge clock);
    check("sb_drained", sb.size(), 32'd0);
    check("overrun_sticky", {31'b0, overrun}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
